// File: rtl/ffn_output_streamer_pkg.sv
// Shared feed-forward network constants and FSM encodings.
// The matrix-multiply controller reuses the state encodings below.
package ffn_output_streamer_pkg;

    localparam int FFN_WIDTH        = 16;
    localparam int FFN_NUM_OUTPUT_N = 10;
    localparam int FFN_OUT_WIDTH    = 2 * FFN_WIDTH;
    localparam int FFN_PIPE_LATENCY = 6;
    localparam int FFN_IDX_WIDTH    = 4;

    localparam logic [1:0] ENC_IDLE   = 2'd0;
    localparam logic [1:0] ENC_WAIT   = 2'd1;
    localparam logic [1:0] ENC_STREAM = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = ENC_IDLE,
        ST_WAIT   = ENC_WAIT,
        ST_STREAM = ENC_STREAM
    } stream_state_e;

endpackage

// File: rtl/ffn_output_streamer_if.sv
// Control, parallel-input and streamed-output signals of the output streamer.
// slave = streamer side, master = controller/consumer side.
interface ffn_output_streamer_if
    import ffn_output_streamer_pkg::*;
#(
    parameter int NUM_OUTPUT_N = FFN_NUM_OUTPUT_N,
    parameter int OUT_WIDTH    = FFN_OUT_WIDTH,
    parameter int IDX_WIDTH    = FFN_IDX_WIDTH
);
    logic                              start;
    logic [OUT_WIDTH*NUM_OUTPUT_N-1:0] output_neurons;
    logic [OUT_WIDTH-1:0]              out_data;
    logic [IDX_WIDTH-1:0]              out_index;
    logic                              out_valid;
    logic                              out_ready;
    logic                              out_last;
    logic                              busy;
    logic                              done;
    logic [IDX_WIDTH-1:0]              max_index;
    logic [OUT_WIDTH-1:0]              max_value;
    logic                              start_dropped;

    modport slave (
        input  start, output_neurons, out_ready,
        output out_data, out_index, out_valid, out_last, busy, done,
               max_index, max_value, start_dropped
    );

    modport master (
        output start, output_neurons, out_ready,
        input  out_data, out_index, out_valid, out_last, busy, done,
               max_index, max_value, start_dropped
    );
endinterface

// File: rtl/ffn_argmax_track.sv
// Running signed argmax over the beats of one frame.
// Latency: result registered on the update edge.
// No backpressure: update is only asserted on accepted beats.
module ffn_argmax_track #(
    parameter int OUT_WIDTH = 32,
    parameter int IDX_WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 update,
    input  logic [OUT_WIDTH-1:0] value,
    input  logic [IDX_WIDTH-1:0] index,
    output logic [OUT_WIDTH-1:0] max_value,
    output logic [IDX_WIDTH-1:0] max_index
);
    logic                 r_empty;
    logic [OUT_WIDTH-1:0] r_max_value;
    logic [IDX_WIDTH-1:0] r_max_index;
    logic                 w_take;

    // Strict greater-than so ties keep the earlier (lower) index.
    assign w_take = r_empty || ($signed(value) > $signed(r_max_value));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_empty     <= 1'b1;
            r_max_value <= '0;
            r_max_index <= '0;
        end else if (clear) begin
            r_empty     <= 1'b1;
            r_max_value <= '0;
            r_max_index <= '0;
        end else if (update && w_take) begin
            r_empty     <= 1'b0;
            r_max_value <= value;
            r_max_index <= index;
        end
    end

    assign max_value = r_max_value;
    assign max_index = r_max_index;
endmodule

// File: rtl/ffn_output_streamer.sv
// Captures the parallel FFN output PIPE_LATENCY edges after start and streams it.
// Latency: first beat valid PIPE_LATENCY+1 cycles after start; one beat per cycle.
// Backpressure: out_ready low stalls the beat in place; starts while busy are dropped.
module ffn_output_streamer
    import ffn_output_streamer_pkg::*;
#(
    parameter int NUM_OUTPUT_N = FFN_NUM_OUTPUT_N,
    parameter int OUT_WIDTH    = FFN_OUT_WIDTH,
    parameter int PIPE_LATENCY = FFN_PIPE_LATENCY,
    parameter int IDX_WIDTH    = FFN_IDX_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    ffn_output_streamer_if.slave bus
);
    localparam int CNT_W = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;

    stream_state_e                     r_state;
    logic [CNT_W-1:0]                  r_cnt;
    logic [IDX_WIDTH-1:0]              r_idx;
    logic [OUT_WIDTH*NUM_OUTPUT_N-1:0] r_capture;
    logic                              r_done;
    logic                              r_drop;
    logic [OUT_WIDTH-1:0]              r_max_value;
    logic [IDX_WIDTH-1:0]              r_max_index;

    logic                 w_valid;
    logic                 w_last;
    logic                 w_xfer;
    logic                 w_capture;
    logic [OUT_WIDTH-1:0] w_data;
    logic [OUT_WIDTH-1:0] w_run_value;
    logic [IDX_WIDTH-1:0] w_run_index;
    logic                 w_take_final;

    assign w_valid   = (r_state == ST_STREAM);
    assign w_last    = w_valid && (r_idx == IDX_WIDTH'(NUM_OUTPUT_N - 1));
    assign w_xfer    = w_valid && bus.out_ready;
    assign w_capture = (r_state == ST_WAIT) && (r_cnt == '0);
    assign w_data    = r_capture[OUT_WIDTH*r_idx +: OUT_WIDTH];

    ffn_argmax_track #(
        .OUT_WIDTH (OUT_WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_argmax (
        .clock     (clock),
        .reset     (reset),
        .clear     (w_capture),
        .update    (w_xfer),
        .value     (w_data),
        .index     (r_idx),
        .max_value (w_run_value),
        .max_index (w_run_index)
    );

    // The published result must include the last beat on its own transfer edge,
    // so fold that beat in here rather than waiting for the tracker register.
    assign w_take_final = (r_idx == '0) || ($signed(w_data) > $signed(w_run_value));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_capture   <= '0;
            r_done      <= 1'b0;
            r_drop      <= 1'b0;
            r_max_value <= '0;
            r_max_index <= '0;
        end else begin
            r_done <= 1'b0;
            r_drop <= bus.start && (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= CNT_W'(PIPE_LATENCY - 1);
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_capture <= bus.output_neurons;
                        r_idx     <= '0;
                        r_state   <= ST_STREAM;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_state     <= ST_IDLE;
                            r_idx       <= '0;
                            r_done      <= 1'b1;
                            r_max_value <= w_take_final ? w_data : w_run_value;
                            r_max_index <= w_take_final ? r_idx  : w_run_index;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.out_valid     = w_valid;
    assign bus.out_data      = w_valid ? w_data : '0;
    assign bus.out_index     = r_idx;
    assign bus.out_last      = w_last;
    assign bus.busy          = (r_state != ST_IDLE);
    assign bus.done          = r_done;
    assign bus.max_index     = r_max_index;
    assign bus.max_value     = r_max_value;
    assign bus.start_dropped = r_drop;
endmodule

// File: tb/tb_ffn_output_streamer.sv
// Directed self-checking bench for ffn_output_streamer (default parameters).
module tb_ffn_output_streamer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] vals [10];
    logic [31:0] got_data [16];
    int          got_n;

    ffn_output_streamer_if #(.NUM_OUTPUT_N(10), .OUT_WIDTH(32), .IDX_WIDTH(4)) bus ();

    ffn_output_streamer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_vals();
        for (int k = 0; k < 10; k++) bus.output_neurons[32*k +: 32] = vals[k];
    endtask

    task automatic set_ramp3();
        for (int k = 0; k < 10; k++) vals[k] = 32'(k * 3);
        apply_vals();
    endtask

    // Pulses start with out_ready high and records every beat until done or budget.
    task automatic run_frame(output bit tmo);
        got_n = 0;
        tmo = 1'b1;
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.out_valid && got_n < 16) begin
                got_data[got_n] = bus.out_data;
                got_n++;
            end
            tick();
            if (bus.done) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d exp 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0d exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0d exp 0", bus.done); end
        checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %0h exp 0", bus.out_data); end
        checks++; if (bus.max_value !== 32'h0 || bus.max_index !== 4'h0) begin errors++; $display("FAIL reset_max got %0h/%0d exp 0/0", bus.max_value, bus.max_index); end
        checks++; if (bus.start_dropped !== 1'b0) begin errors++; $display("FAIL reset_drop got %0d exp 0", bus.start_dropped); end
        #3 reset = 1'b0;
    endtask

    task automatic test_basic();
        set_ramp3();
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %0d exp 1", bus.busy); end
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid cyc %0d got %0d exp 0", i, bus.out_valid); end
        end
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_first_valid got %0d exp 1", bus.out_valid); end
        for (int k = 0; k < 10; k++) begin
            checks++; if (bus.out_data !== 32'(k*3) || bus.out_index !== 4'(k)) begin errors++; $display("FAIL basic_beat %0d got %0d@%0d exp %0d@%0d", k, bus.out_data, bus.out_index, k*3, k); end
            checks++; if (bus.out_last !== (k == 9) || bus.done !== 1'b0) begin errors++; $display("FAIL basic_last_done %0d got %0d/%0d exp %0d/0", k, bus.out_last, bus.done, (k == 9)); end
            tick();
        end
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL basic_done got done=%0d busy=%0d exp 1/0", bus.done, bus.busy); end
        checks++; if (bus.max_index !== 4'd9 || bus.max_value !== 32'd27) begin errors++; $display("FAIL basic_max got %0d/%0d exp 9/27", bus.max_index, bus.max_value); end
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %0d exp 0", bus.done); end
    endtask

    task automatic test_backpressure();
        int n = 0;
        int dones = 0;
        set_ramp3();
        bus.out_ready = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 20 && !bus.out_valid; c++) tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout got %0d exp 1", bus.out_valid); end
        for (int c = 0; c < 60; c++) begin
            bus.out_ready = (c % 3 == 0);
            if (bus.out_valid) begin
                checks++; if (bus.out_data !== 32'(n*3) || bus.out_index !== 4'(n)) begin errors++; $display("FAIL bp_beat %0d got %0d@%0d exp %0d@%0d", n, bus.out_data, bus.out_index, n*3, n); end
                if (bus.out_ready) n++;
            end
            tick();
            if (bus.done) begin
                dones++;
                checks++; if (n !== 10) begin errors++; $display("FAIL bp_done_early got %0d beats exp 10", n); end
            end
        end
        checks++; if (n !== 10 || dones !== 1) begin errors++; $display("FAIL bp_totals got %0d beats %0d dones exp 10/1", n, dones); end
        checks++; if (bus.max_index !== 4'd9 || bus.max_value !== 32'd27) begin errors++; $display("FAIL bp_max got %0d/%0d exp 9/27", bus.max_index, bus.max_value); end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_signed_tie();
        bit tmo;
        vals[0] = 32'hFFFF_FFFB; vals[1] = 32'h8000_0000; vals[2] = 32'd7; vals[3] = 32'd7;
        vals[4] = 32'hFFFF_FFFF;
        for (int k = 5; k < 10; k++) vals[k] = 32'd0;
        apply_vals();
        run_frame(tmo);
        checks++; if (tmo !== 1'b0 || got_n !== 10) begin errors++; $display("FAIL signed_frame got tmo=%0d beats=%0d exp 0/10", tmo, got_n); end
        checks++; if (got_data[1] !== 32'h8000_0000) begin errors++; $display("FAIL signed_beat1 got %0h exp 80000000", got_data[1]); end
        checks++; if (bus.max_index !== 4'd2 || bus.max_value !== 32'd7) begin errors++; $display("FAIL signed_max got %0d/%0h exp 2/7", bus.max_index, bus.max_value); end
        for (int k = 0; k < 10; k++) vals[k] = 32'hFFFF_FFFF;
        apply_vals();
        tick();
        run_frame(tmo);
        checks++; if (tmo !== 1'b0 || got_n !== 10) begin errors++; $display("FAIL allneg_frame got tmo=%0d beats=%0d exp 0/10", tmo, got_n); end
        checks++; if (bus.max_index !== 4'd0 || bus.max_value !== 32'hFFFF_FFFF) begin errors++; $display("FAIL allneg_max got %0d/%0h exp 0/ffffffff", bus.max_index, bus.max_value); end
    endtask

    task automatic test_capture_drop();
        int drops = 0;
        bit saw_valid = 1'b0;
        for (int k = 0; k < 10; k++) vals[k] = 32'(100 + k);
        apply_vals();
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 10; j++) bus.output_neurons[32*j +: 32] = $urandom;
            checks++; if (bus.out_data !== 32'(100 + k)) begin errors++; $display("FAIL cap_beat %0d got %0d exp %0d", k, bus.out_data, 100 + k); end
            bus.start = (k == 3);
            tick();
            if (bus.start_dropped) drops++;
        end
        bus.start = 1'b0;
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL cap_done got %0d exp 1", bus.done); end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.start_dropped) drops++;
            if (bus.out_valid || bus.busy) saw_valid = 1'b1;
        end
        checks++; if (drops !== 1) begin errors++; $display("FAIL cap_drops got %0d exp 1", drops); end
        checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL cap_second_frame got %0d exp 0", saw_valid); end
        checks++; if (bus.max_index !== 4'd9 || bus.max_value !== 32'd109) begin errors++; $display("FAIL cap_max got %0d/%0d exp 9/109", bus.max_index, bus.max_value); end
    endtask

    task automatic test_back_to_back();
        bit seen = 1'b0;
        set_ramp3();
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 40 && !bus.done; c++) tick();
        checks++; if (bus.done !== 1'b1 || bus.max_value !== 32'd27) begin errors++; $display("FAIL b2b_first got done=%0d max=%0d exp 1/27", bus.done, bus.max_value); end
        vals[0] = 32'd1; vals[1] = 32'd2; vals[2] = 32'd3; vals[3] = 32'd4; vals[4] = 32'd50;
        for (int k = 5; k < 10; k++) vals[k] = 32'd0;
        apply_vals();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.start_dropped !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got drop=%0d busy=%0d exp 0/1", bus.start_dropped, bus.busy); end
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b0 || bus.max_value !== 32'd27) begin errors++; $display("FAIL b2b_wait %0d got valid=%0d max=%0d exp 0/27", i, bus.out_valid, bus.max_value); end
        end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd1) begin errors++; $display("FAIL b2b_first_beat got valid=%0d data=%0d exp 1/1", bus.out_valid, bus.out_data); end
        for (int c = 0; c < 20 && !seen; c++) begin
            checks++; if (bus.max_value !== 32'd27 || bus.max_index !== 4'd9) begin errors++; $display("FAIL b2b_held got %0d/%0d exp 9/27", bus.max_index, bus.max_value); end
            tick();
            seen = bus.done;
        end
        checks++; if (seen !== 1'b1 || bus.max_index !== 4'd4 || bus.max_value !== 32'd50) begin errors++; $display("FAIL b2b_second got done=%0d max=%0d/%0d exp 1 4/50", seen, bus.max_index, bus.max_value); end
    endtask

    task automatic test_reset_mid();
        bit tmo;
        bit saw_done = 1'b0;
        set_ramp3();
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        #3 reset = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.max_value !== 32'd0 || bus.max_index !== 4'd0) begin errors++; $display("FAIL rst_wait got busy=%0d max=%0d/%0d exp 0 0/0", bus.busy, bus.max_index, bus.max_value); end
        @(posedge clock);
        #3 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rst_wait_resume got %0d exp 0", saw_done); end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        for (int k = 0; k < 4; k++) tick();
        checks++; if (bus.out_index !== 4'd4 || bus.out_data !== 32'd12) begin errors++; $display("FAIL rst_pre_idx got %0d/%0d exp 4/12", bus.out_index, bus.out_data); end
        #3 reset = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'd0 || bus.out_index !== 4'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_stream got v=%0d d=%0d i=%0d b=%0d exp 0 0 0 0", bus.out_valid, bus.out_data, bus.out_index, bus.busy); end
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            if (bus.done) saw_done = 1'b1;
        end
        #2 reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rst_no_done got %0d exp 0", saw_done); end
        run_frame(tmo);
        checks++; if (tmo !== 1'b0 || got_n !== 10) begin errors++; $display("FAIL rst_clean_frame got tmo=%0d beats=%0d exp 0/10", tmo, got_n); end
        for (int k = 0; k < 10; k++) begin
            checks++; if (got_data[k] !== 32'(k*3)) begin errors++; $display("FAIL rst_clean_beat %0d got %0d exp %0d", k, got_data[k], k*3); end
        end
        checks++; if (bus.max_index !== 4'd9 || bus.max_value !== 32'd27) begin errors++; $display("FAIL rst_clean_max got %0d/%0d exp 9/27", bus.max_index, bus.max_value); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        bus.output_neurons = '0;
        test_reset();
        test_basic();
        tick();
        test_backpressure();
        tick();
        test_signed_tie();
        tick();
        test_capture_drop();
        test_back_to_back();
        tick();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ffn_output_streamer.md
Name: ffn_output_streamer

Overview:
- Sits on the output side of the single-layer feed-forward matrix multiply.
- Waits a fixed pipeline latency after each compute start, then captures the wide parallel output_neurons vector in one cycle.
- Streams the captured neurons out one per cycle over a valid/ready handshake.
- Tracks the signed argmax while streaming, which the softmax/classification stage consumes at the end of each frame.

Parameters:
- NUM_OUTPUT_N, 10, number of output neurons; defaults from `NUM_OUTPUT_N.
- OUT_WIDTH, 32, width of one output neuron (2*`FFN_WIDTH); signed two's complement.
- PIPE_LATENCY, 6, cycles from the start pulse to valid output_neurons (multiplier plus adder-tree depth); legal range >= 1.
- IDX_WIDTH, 4, index width; must satisfy 2^IDX_WIDTH >= NUM_OUTPUT_N.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse: operands were applied to the multiply this cycle.
- output_neurons  input  OUT_WIDTH*NUM_OUTPUT_N  parallel layer output; neuron k is at bits [OUT_WIDTH*k +: OUT_WIDTH].
- out_data  output  OUT_WIDTH  current streamed neuron.
- out_index  output  IDX_WIDTH  index of out_data.
- out_valid  output  1  out_data/out_index are valid.
- out_ready  input  1  downstream accepts the beat.
- out_last  output  1  high with the beat for index NUM_OUTPUT_N-1.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse after the last beat is accepted.
- max_index  output  IDX_WIDTH  argmax of the completed frame; held until the next done.
- max_value  output  OUT_WIDTH  value at max_index; held until the next done.
- start_dropped  output  1  one-cycle pulse when start arrives while busy.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All outputs go to 0, including max_index and max_value.
  - The capture register and latency counter clear.
  - Reset mid-stream abandons the frame; no done pulse is produced.
- FSM states: IDLE, WAIT, STREAM.
- IDLE:
  - start=1 moves to WAIT and loads the counter with PIPE_LATENCY-1.
- WAIT:
  - The counter decrements each cycle.
  - When the counter is 0, the capture register samples output_neurons on that edge. This edge is exactly PIPE_LATENCY edges after the start edge.
  - On the same edge: state -> STREAM, idx=0, running max cleared to "empty".
- STREAM:
  - out_valid=1.
  - out_data = captured[idx].
  - out_index = idx.
  - out_last = (idx == NUM_OUTPUT_N-1).
- Handshake:
  - A beat transfers on a rising edge with out_valid && out_ready.
  - With out_ready=0, out_data, out_index and out_last hold stable. out_valid never drops once raised until the transfer.
  - On transfer, idx increments.
- Argmax:
  - On each transfer, the running max updates if the frame is empty or the signed comparison gives out_data > max.
  - Ties keep the lower index.
  - The comparison uses the full OUT_WIDTH; 0x80000000 is the most negative value.
- End of frame:
  - A transfer with out_last=1 moves state to IDLE.
  - done=1 for exactly the next cycle.
  - max_index/max_value update on that same edge to the final frame result.
- A start during the done cycle (state IDLE) is accepted normally.
- A start in WAIT or STREAM is ignored: no restart, no effect on the capture, and start_dropped pulses for one cycle.
- Captured data is immune to output_neurons changes after the capture edge.
- Latency: first beat valid PIPE_LATENCY+1 cycles after start; minimum frame length NUM_OUTPUT_N beats.
- PIPE_LATENCY=1: WAIT lasts one cycle.
- NUM_OUTPUT_N=1: a single beat with out_last=1.

Decomposition:
- OUT_WIDTH and NUM_OUTPUT_N derive from shared network_params.h macros (`FFN_WIDTH, `NUM_OUTPUT_N).
- FSM state encodings go as localparams in the same shared header so the matrix-multiply controller can reuse them.
- One sub-module is natural: ffn_argmax_track.
  - Signed compare and register of max_value/max_index.
  - Ports: clock, reset, clear, update, value, index, max_value, max_index.

Test Plan:
1. Basic frame: PIPE_LATENCY=6, start at cycle 0, output_neurons = {k*3 : k=0..9}, out_ready=1 throughout -> out_valid first at cycle 7; beats 0,3,...,27 on consecutive cycles; out_last on index 9; done at cycle 17; max_index=9, max_value=27.
2. Backpressure: same data, out_ready toggles 1,0,0,1,... -> no beat lost or duplicated; out_data holds during stalls; done only after the 10th accepted beat.
3. Signed and tie argmax: values {-5, 0x80000000, 7, 7, -1, 0...} -> max_index=2, max_value=7; then a frame of all 0xFFFFFFFF -> max_index=0, max_value=-1.
4. Capture isolation and drop: change output_neurons every cycle after the capture edge, and pulse start during STREAM -> streamed values equal the capture-edge snapshot; start_dropped pulses once; no second frame occurs.
5. Back-to-back: start in the done cycle -> the new frame's first beat arrives PIPE_LATENCY+1 cycles later; the previous max stays held until the new done.
6. Reset mid-operation: assert reset asynchronously (between edges) during WAIT and again at idx=4 of STREAM -> all outputs are 0 immediately; no done pulse; the next start produces a clean full frame.
